// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALUop codes, flag bit
// positions, default datapath width and the response-slot state type.
package alu_arbiter_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_COUT = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/alu_arb_grant2.sv
// Two-way grant generator with a round-robin pointer. Defining
// ALU_ARBITER_FIXED_PRIO_EN makes requester 0 always win and drops the pointer.
module alu_arb_grant2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  logic ptr;
  logic [1:0] elig_g;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
  assign ptr = 1'b0;
`else
  logic ptr_q, ptr_d;

  // The pointer moves to the requester that lost this cycle; idle cycles hold it.
  always_comb begin
    ptr_d = ptr_q;
    if (grant != 2'b00) ptr_d = grant[0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  // NOTE: grant gets a default before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    elig_g = rst ? 2'b00 : eligible;
    grant  = 2'b00;
    case (elig_g)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters; each requester owns a
// one-entry response slot. Build option: ALU_ARBITER_FIXED_PRIO_EN.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_A,
  input  logic [2*DATA_W-1:0] req_B,
  input  logic [7:0]          req_op,
  output logic [DATA_W-1:0]   alu_A,
  output logic [DATA_W-1:0]   alu_B,
  output logic [3:0]          alu_op,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [2:0]          alu_flags,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic [5:0]          rsp_flags
);

  slot_state_t       slot_q   [2];
  slot_state_t       slot_d   [2];
  logic [DATA_W-1:0] result_q [2];
  logic [DATA_W-1:0] result_d [2];
  logic [2:0]        flags_q  [2];
  logic [2:0]        flags_d  [2];

  logic [1:0] eligible;
  logic [1:0] grant;

  // A full slot can accept new work in the same cycle it is being drained.
  always_comb begin
    eligible = 2'b00;
    for (int i = 0; i < 2; i++)
      eligible[i] = req_valid[i] & ((slot_q[i] == SLOT_EMPTY) | rsp_ready[i]);
  end

  alu_arb_grant2 u_grant (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible),
    .grant    (grant)
  );

  assign req_ready = grant;

  always_comb begin
    alu_A  = '0;
    alu_B  = '0;
    alu_op = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) begin
        alu_A  = req_A[i*DATA_W +: DATA_W];
        alu_B  = req_B[i*DATA_W +: DATA_W];
        alu_op = req_op[i*4 +: 4];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      slot_d[i]   = slot_q[i];
      result_d[i] = result_q[i];
      flags_d[i]  = flags_q[i];
      if (grant[i]) begin
        slot_d[i]   = SLOT_FULL;
        result_d[i] = alu_result;
        flags_d[i]  = alu_flags;
      end else if (slot_q[i] == SLOT_FULL && rsp_ready[i]) begin
        slot_d[i] = SLOT_EMPTY;
      end
    end
  end

  // NOTE: the result/flag registers are reset as well as the state, because the
  // response ports must read zero immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        slot_q[i]   <= SLOT_EMPTY;
        result_q[i] <= '0;
        flags_q[i]  <= 3'b000;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        slot_q[i]   <= slot_d[i];
        result_q[i] <= result_d[i];
        flags_q[i]  <= flags_d[i];
      end
    end
  end

  always_comb begin
    rsp_valid  = 2'b00;
    rsp_result = '0;
    rsp_flags  = 6'b000000;
    for (int i = 0; i < 2; i++) begin
      rsp_valid[i]                    = (slot_q[i] == SLOT_FULL);
      rsp_result[i*DATA_W +: DATA_W]  = result_q[i];
      rsp_flags[i*3 +: 3]             = flags_q[i];
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU attached; honours
// ALU_ARBITER_FIXED_PRIO_EN in its grant model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_A, req_B;
  logic [7:0]     req_op;
  logic [W-1:0]   alu_A, alu_B, alu_result;
  logic [3:0]     alu_op;
  logic [2:0]     alu_flags;
  logic [1:0]     rsp_valid, rsp_ready;
  logic [2*W-1:0] rsp_result;
  logic [5:0]     rsp_flags;

  int n_cmp = 0;
  int n_err = 0;

  logic        m_ptr;
  logic [1:0]  m_full;
  logic [34:0] m_last [2];
  logic [34:0] sb0 [$];
  logic [34:0] sb1 [$];

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A      (req_A),
    .req_B      (req_B),
    .req_op     (req_op),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  // Reference ALU: returns {Overflow, CarryOut, Zero, Result}.
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic c, o;
    s = '0; r = '0; c = 1'b0; o = 1'b0;
    case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALU_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_NOR: r = ~(a | b);
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = a << b[4:0];
      ALU_SRL: r = a >> b[4:0];
      ALU_SRA: r = $signed(a) >>> b[4:0];
      default: r = '0;
    endcase
    return {o, c, (r == 32'd0), r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_f(alu_A, alu_B, alu_op);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus at posedge+1, checks the combinational
  // outputs, then checks the response slots just after the next edge.
  task automatic step(input logic [1:0] v,
                      input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                      input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                      input logic [1:0] rr);
    logic [1:0]  elig, g;
    logic [34:0] e;
    req_valid = v;
    req_A     = {a1, a0};
    req_B     = {b1, b0};
    req_op    = {op1, op0};
    rsp_ready = rr;
    #1;
    elig = v & (~m_full | rr);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    g = (elig == 2'b11) ? 2'b01 : elig;
`else
    g = (elig == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : elig;
`endif
    check("req_ready", req_ready, g);
    check("alu_op", alu_op, g[0] ? op0 : (g[1] ? op1 : 4'b0000));
    check("alu_A",  alu_A,  g[0] ? a0  : (g[1] ? a1  : 32'd0));
    check("alu_B",  alu_B,  g[0] ? b0  : (g[1] ? b1  : 32'd0));
    if (g[0]) sb0.push_back(alu_f(a0, b0, op0));
    if (g[1]) sb1.push_back(alu_f(a1, b1, op1));
    for (int i = 0; i < 2; i++) begin
      if (g[i])       m_full[i] = 1'b1;
      else if (rr[i]) m_full[i] = 1'b0;
    end
    if (g != 2'b00) m_ptr = g[0];
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (g[i]) begin
        e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
        m_last[i] = e;
        check("rsp_valid_load", rsp_valid[i], 1'b1);
        check("rsp_result", rsp_result[i*W +: W], e[31:0]);
        check("rsp_flags",  rsp_flags[i*3 +: 3], e[34:32]);
      end else begin
        check("rsp_valid", rsp_valid[i], m_full[i]);
        if (m_full[i]) begin
          check("rsp_result_hold", rsp_result[i*W +: W], m_last[i][31:0]);
          check("rsp_flags_hold",  rsp_flags[i*3 +: 3], m_last[i][34:32]);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; req_A = '0; req_B = '0; req_op = '0; rsp_ready = 2'b00;
    m_ptr = 1'b0; m_full = 2'b00; m_last[0] = '0; m_last[1] = '0;
    #2;
    check("reset_rsp_valid",  rsp_valid,  2'b00);
    check("reset_rsp_result", rsp_result, 64'd0);
    check("reset_rsp_flags",  rsp_flags,  6'd0);
    check("reset_req_ready",  req_ready,  2'b00);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request: 5 + 3 lands in slot 0 one cycle later.
    step(2'b01, 32'd5, 32'd3, ALU_ADD, 32'd0, 32'd0, ALU_AND, 2'b00);
    check("single_result", rsp_result[31:0], 32'd8);
    check("single_flags",  rsp_flags[2:0], 3'b000);

    // Load slot 1 while slot 0 drains, then backpressure slot 1.
    step(2'b10, 32'd0, 32'd0, ALU_AND, 32'd10, 32'd3, ALU_SUB, 2'b01);
    step(2'b11, 32'hF0F0, 32'h0FF0, ALU_AND, 32'd1, 32'd1, ALU_OR, 2'b00);
    check("backpressure_hold", rsp_result[63:32], 32'd7);

    // Idle with both slots draining.
    step(2'b00, 32'd9, 32'd9, ALU_XOR, 32'd9, 32'd9, ALU_XOR, 2'b11);

    // Contention with both consumers ready.
    for (int k = 0; k < 4; k++)
      step(2'b11, k, 32'd1, ALU_ADD, 32'd100 + k, 32'd2, ALU_SLL, 2'b11);

    // Drain-and-reload of slot 0 with a signed-overflow subtract.
    step(2'b01, 32'h8000_0000, 32'd1, ALU_SUB, 32'd0, 32'd0, ALU_AND, 2'b01);
    check("drain_load_valid",  rsp_valid[0], 1'b1);
    check("drain_load_result", rsp_result[31:0], 32'h7FFF_FFFF);
    check("drain_load_ovf",    rsp_flags[FLAG_OVF], 1'b1);

    // Full throughput on requester 0.
    for (int k = 0; k < 4; k++)
      step(2'b01, 32'd7 * k, 32'd3, ALU_SRA, 32'd0, 32'd0, ALU_AND, 2'b01);

    // Random mix including the undefined opcodes 10..15.
    for (int k = 0; k < 60; k++)
      step(2'($urandom_range(0, 3)),
           $urandom, $urandom, 4'($urandom_range(0, 15)),
           $urandom, $urandom, 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)));

    // Fill both slots, then reset asynchronously in mid-cycle.
    step(2'b00, 32'd0, 32'd0, ALU_AND, 32'd0, 32'd0, ALU_AND, 2'b11);
    step(2'b01, 32'd1, 32'd2, ALU_ADD, 32'd0, 32'd0, ALU_AND, 2'b00);
    step(2'b10, 32'd0, 32'd0, ALU_AND, 32'd6, 32'd1, ALU_SRL, 2'b00);
    check("prereset_full", rsp_valid, 2'b11);
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    #3 rst = 1'b1;
    #1;
    check("async_rsp_valid",  rsp_valid,  2'b00);
    check("async_rsp_result", rsp_result, 64'd0);
    check("async_rsp_flags",  rsp_flags,  6'd0);
    check("rst_no_grant",     req_ready,  2'b00);
    m_full = 2'b00;
    m_ptr  = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(2'b11, 32'd4, 32'd4, ALU_SUB, 32'd8, 32'd8, ALU_NOR, 2'b00);
    check("post_reset_grant_r0", rsp_valid, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
